ram_in_writer: RTL and testbench

//   Frame-buffer writer: assembles a byte stream (e.g. UART RX) into 24-bit RGB pixels
//   and writes them, in raster order, into the 512x384 image RAM read by the display path.

---
 rtl/ram_in_writer.sv | 122 ++++++++++++
 tb/tb_ram_in_writer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ram_in_writer.sv
// Frame-buffer writer: packs an R,G,B byte stream into 24-bit pixels and writes
// one full frame into the image RAM in raster order, once per start pulse.
module ram_in_writer #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 384,
  parameter int ADDR_W = 18,
  parameter int PIX_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  pix_out,
  output logic              we,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  state_t              state_reg, state_next;
  logic [1:0]          byte_cnt_reg, byte_cnt_next;
  logic [7:0]          r_reg, r_next;
  logic [7:0]          g_reg, g_next;
  logic [ADDR_W-1:0]   pix_idx_reg, pix_idx_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [PIX_W-1:0]    pix_reg, pix_next;
  logic                we_reg, we_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= 2'd0;
      r_reg        <= 8'd0;
      g_reg        <= 8'd0;
      pix_idx_reg  <= '0;
      addr_reg     <= '0;
      pix_reg      <= '0;
      we_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      r_reg        <= r_next;
      g_reg        <= g_next;
      pix_idx_reg  <= pix_idx_next;
      addr_reg     <= addr_next;
      pix_reg      <= pix_next;
      we_reg       <= we_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    r_next        = r_reg;
    g_next        = g_reg;
    pix_idx_next  = pix_idx_reg;
    addr_next     = addr_reg;
    pix_next      = pix_reg;
    we_next       = 1'b0;
    busy_next     = busy_reg;
    done_next     = done_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next    = RECV;
          busy_next     = 1'b1;
          done_next     = 1'b0;
          byte_cnt_next = 2'd0;
          pix_idx_next  = '0;
        end
      end
      RECV: begin
        // The third byte completes the pixel directly from rx_data, so a byte
        // arriving during the write cycle is already the next pixel's R.
        if (rx_valid) begin
          case (byte_cnt_reg)
            2'd0: begin
              r_next        = rx_data;
              byte_cnt_next = 2'd1;
            end
            2'd1: begin
              g_next        = rx_data;
              byte_cnt_next = 2'd2;
            end
            default: begin
              byte_cnt_next = 2'd0;
              we_next       = 1'b1;
              addr_next     = pix_idx_reg;
              pix_next      = PIX_W'({r_reg, g_reg, rx_data});
              pix_idx_next  = pix_idx_reg + ADDR_W'(1);
              if (pix_idx_reg == LAST_ADDR) begin
                state_next = DONE;
                busy_next  = 1'b0;
                done_next  = 1'b1;
              end
            end
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign addr    = addr_reg;
  assign pix_out = pix_reg;
  assign we      = we_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_ram_in_writer.sv
// Bench for ram_in_writer on a reduced 16x12 frame: directed vector table,
// then randomized frames checked against a queue-based reference model.
module tb_ram_in_writer;

  localparam int IMG_W  = 16;
  localparam int IMG_H  = 12;
  localparam int ADDR_W = 8;
  localparam int PIX_W  = 24;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst, start, rx_valid;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  pix_out;
  logic              we, busy, done;

  int compared   = 0;
  int mismatched = 0;

  ram_in_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .addr(addr), .pix_out(pix_out), .we(we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM written by the DUT, compared against the model's expected image
  logic [PIX_W-1:0] ram_act [0:(1<<ADDR_W)-1];
  logic [PIX_W-1:0] exp_ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) if (we) ram_act[addr] <= pix_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        r, s, v;
    logic [7:0]  d;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [23:0] e_pix;
    logic        e_busy, e_done;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic v, logic [7:0] d, logic e_we,
                              logic [7:0] e_addr, logic [23:0] e_pix, logic e_busy, logic e_done);
    vec_t t;
    t.r = r; t.s = s; t.v = v; t.d = d; t.e_we = e_we; t.e_addr = e_addr;
    t.e_pix = e_pix; t.e_busy = e_busy; t.e_done = e_done;
    return t;
  endfunction

  // Reference model: a frame is a flat list of bytes; every three accepted bytes
  // form the next pixel, written at the next raster index until the frame is full.
  logic        m_armed = 1'b0, m_done = 1'b0;
  int          m_idx   = 0;
  logic [7:0]  m_addr  = '0;
  logic [23:0] m_pix   = '0;
  logic [7:0]  pend[$];

  task automatic cycle(input logic r, input logic s, input logic v, input logic [7:0] d);
    logic ew;
    ew = 1'b0;
    if (r) begin
      m_armed = 1'b0; m_done = 1'b0; m_idx = 0; m_addr = '0; m_pix = '0;
      pend.delete();
    end else if (!m_armed) begin
      if (s) begin
        m_armed = 1'b1; m_done = 1'b0; m_idx = 0;
        pend.delete();
      end
    end else if (v) begin
      pend.push_back(d);
      if (pend.size() == 3) begin
        ew     = 1'b1;
        m_addr = m_idx[7:0];
        m_pix  = {pend[0], pend[1], pend[2]};
        exp_ram[m_idx] = m_pix;
        pend.delete();
        m_idx++;
        if (m_idx == NPIX) begin
          m_armed = 1'b0;
          m_done  = 1'b1;
        end
      end
    end
    rst = r; start = s; rx_valid = v; rx_data = d;
    @(posedge clk); #1;
    chk("we", we, ew);
    chk("busy", busy, m_armed);
    chk("done", done, m_done);
    chk("addr", addr, m_addr);
    chk("pix_out", pix_out, m_pix);
  endtask

  task automatic run_frame(input int valid_pct, input int start_pct);
    int guard;
    guard = 0;
    while (m_armed && guard < 5000) begin
      cycle(1'b0, ($urandom_range(99) < start_pct), ($urandom_range(99) < valid_pct),
            8'($urandom));
      guard++;
    end
    chk("frame_timeout", guard < 5000, 1'b1);
  endtask

  task automatic check_ram(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      chk("ram", ram_act[i], exp_ram[i]);
      if (ram_act[i] !== exp_ram[i]) bad++;
    end
    $display("ram check %s: %0d addresses, %0d differ", tag, NPIX, bad);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    // rst | start | valid | data || we | addr | pix | busy | done
    vecs.push_back(mk(1,0,0,8'h00, 0,8'd0,24'h000000, 0,0));
    vecs.push_back(mk(0,0,1,8'h11, 0,8'd0,24'h000000, 0,0));
    vecs.push_back(mk(0,0,1,8'h22, 0,8'd0,24'h000000, 0,0));
    vecs.push_back(mk(0,0,1,8'h33, 0,8'd0,24'h000000, 0,0));
    vecs.push_back(mk(0,1,0,8'h00, 0,8'd0,24'h000000, 1,0));
    vecs.push_back(mk(0,0,1,8'hAA, 0,8'd0,24'h000000, 1,0));
    vecs.push_back(mk(0,0,1,8'hBB, 0,8'd0,24'h000000, 1,0));
    vecs.push_back(mk(0,0,1,8'hCC, 1,8'd0,24'hAABBCC, 1,0));
    vecs.push_back(mk(0,0,0,8'h00, 0,8'd0,24'hAABBCC, 1,0));
    vecs.push_back(mk(0,0,1,8'h01, 0,8'd0,24'hAABBCC, 1,0));
    vecs.push_back(mk(0,0,1,8'h02, 0,8'd0,24'hAABBCC, 1,0));
    vecs.push_back(mk(0,0,1,8'h03, 1,8'd1,24'h010203, 1,0));
    vecs.push_back(mk(0,1,1,8'h04, 0,8'd1,24'h010203, 1,0));
    vecs.push_back(mk(0,0,1,8'h05, 0,8'd1,24'h010203, 1,0));
    vecs.push_back(mk(0,0,1,8'h06, 1,8'd2,24'h040506, 1,0));
    vecs.push_back(mk(0,0,0,8'h00, 0,8'd2,24'h040506, 1,0));
    vecs.push_back(mk(0,0,1,8'h07, 0,8'd2,24'h040506, 1,0));
    vecs.push_back(mk(0,0,1,8'h08, 0,8'd2,24'h040506, 1,0));
    vecs.push_back(mk(1,0,0,8'h00, 0,8'd0,24'h000000, 0,0));
    vecs.push_back(mk(0,0,1,8'h09, 0,8'd0,24'h000000, 0,0));
    vecs.push_back(mk(0,1,0,8'h00, 0,8'd0,24'h000000, 1,0));
    vecs.push_back(mk(0,0,1,8'h0A, 0,8'd0,24'h000000, 1,0));
    vecs.push_back(mk(0,0,1,8'h0B, 0,8'd0,24'h000000, 1,0));
    vecs.push_back(mk(0,0,1,8'h0C, 1,8'd0,24'h0A0B0C, 1,0));
    vecs.push_back(mk(0,0,0,8'h00, 0,8'd0,24'h0A0B0C, 1,0));

    foreach (vecs[i]) begin
      rst = vecs[i].r; start = vecs[i].s; rx_valid = vecs[i].v; rx_data = vecs[i].d;
      @(posedge clk); #1;
      chk("vec_we", we, vecs[i].e_we);
      chk("vec_addr", addr, vecs[i].e_addr);
      chk("vec_pix", pix_out, vecs[i].e_pix);
      chk("vec_busy", busy, vecs[i].e_busy);
      chk("vec_done", done, vecs[i].e_done);
      $display("vec %0d: rst=%b start=%b v=%b d=%h -> we=%b addr=%0d pix=%h busy=%b done=%b",
               i, vecs[i].r, vecs[i].s, vecs[i].v, vecs[i].d, we, addr, pix_out, busy, done);
    end

    // Frame 1: random gaps and stray start pulses that must be ignored mid-frame
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    run_frame(70, 5);
    $display("frame 1: %0d pixels, done=%b busy=%b", m_idx, done, busy);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
    check_ram("frame 1");

    // Frame 2 from DONE: byte on every cycle, no gaps
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    run_frame(100, 0);
    $display("frame 2: %0d pixels, done=%b busy=%b", m_idx, done, busy);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check_ram("frame 2");

    // Stalled frame stays busy until reset
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1, 8'($urandom));
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    $display("stalled frame: busy=%b after 20 idle cycles", busy);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
